// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Holds the receiver FSM state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/fifo_stack.sv
// Circular-buffer FIFO used as the UART receive queue.
// Head byte reads as zero while empty so the output is defined.
module fifo_stack #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   size,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign empty   = (count == '0);
    assign size    = count;
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchroniser, centre-sampling FSM, receive FIFO,
// sticky error flags and RTS flow control.
module uart_rx
    import uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int RTS_MARGIN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                rx,
    output logic                rts,
    input  logic                flow_ctrl,
    input  logic                parity,
    input  logic                stop_bits,
    input  logic                data_bits,
    input  logic [23:0]         baud_reg,
    input  logic                pop,
    output logic [7:0]          data_out,
    output logic [ADDR_WIDTH:0] size,
    output logic                empty,
    output logic                full,
    output logic                frame_error,
    output logic                parity_error,
    output logic                overrun_error
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    rx_state_t   state;
    logic        rx_q;
    logic        rx_s;
    logic [23:0] counter;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_ok;
    logic        stop_ok;
    logic        push_req;
    logic        push;
    logic [23:0] half_m1;
    logic [23:0] bit_m1;
    logic [2:0]  last_idx;
    logic [31:0] free_slots;
    logic        unused_cfg;

    // Only the first stop bit is sampled; the second is plain idle time.
    assign unused_cfg = stop_bits;

    assign half_m1    = {1'b0, baud_reg[23:1]} - 24'd1;
    assign bit_m1     = baud_reg - 24'd1;
    assign last_idx   = data_bits ? 3'd7 : 3'd6;
    assign push       = push_req && !full;
    assign free_slots = 32'(DEPTH) - 32'(size);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_q <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_q <= rx;
            rx_s <= rx_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            counter   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            parity_ok <= 1'b0;
            stop_ok   <= 1'b0;
            push_req  <= 1'b0;
        end else begin
            push_req <= 1'b0;
            unique case (state)
                IDLE: begin
                    counter <= '0;
                    bit_idx <= '0;
                    if (!rx_s) begin
                        shift <= '0;
                        state <= START;
                    end
                end
                START: begin
                    if (counter == half_m1) begin
                        counter <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        counter <= counter + 24'd1;
                    end
                end
                DATA: begin
                    if (counter == bit_m1) begin
                        counter        <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == last_idx) begin
                            state <= parity ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        counter <= counter + 24'd1;
                    end
                end
                PARITY: begin
                    if (counter == bit_m1) begin
                        counter   <= '0;
                        parity_ok <= (rx_s == ^shift);
                        state     <= STOP;
                    end else begin
                        counter <= counter + 24'd1;
                    end
                end
                STOP: begin
                    if (counter == bit_m1) begin
                        counter  <= '0;
                        stop_ok  <= rx_s;
                        push_req <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        counter <= counter + 24'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A full FIFO drops the byte even if a pop lands on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else if (clear) begin
            frame_error   <= 1'b0;
            parity_error  <= 1'b0;
            overrun_error <= 1'b0;
        end else if (push_req) begin
            if (full) begin
                overrun_error <= 1'b1;
            end else begin
                if (!stop_ok) begin
                    frame_error <= 1'b1;
                end
                if (parity && !parity_ok) begin
                    parity_error <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rts <= 1'b1;
        end else begin
            rts <= flow_ctrl && (free_slots <= 32'(RTS_MARGIN));
        end
    end

    fifo_stack #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .clear(clear),
        .push (push),
        .pop  (pop),
        .din  (shift),
        .dout (data_out),
        .size (size),
        .empty(empty),
        .full (full)
    );

endmodule
